// File: rtl/hwce_yin_streamer_if.sv
// Handshake bundle between the y_in streamer, the memory streamer feeding it
// packed partial sums, and the shift-adder consuming y_in vectors.
// master: the y_in streamer side. slave: the environment (stream source + adder).
interface hwce_yin_streamer_if #(
   parameter int CONV_WIDTH   = 16,
   parameter int NPX          = 4,
   parameter int STREAM_WIDTH = 32
);
   logic [STREAM_WIDTH-1:0]   stream_data;
   logic                      stream_valid;
   logic                      stream_ready;
   logic [NPX*CONV_WIDTH-1:0] y_in;
   logic                      valid_y_in;
   logic                      ready_in;
   logic                      sum_over_constant;

   modport master (
      input  stream_data, stream_valid, ready_in,
      output stream_ready, y_in, valid_y_in, sum_over_constant
   );

   modport slave (
      output stream_data, stream_valid, ready_in,
      input  stream_ready, y_in, valid_y_in, sum_over_constant
   );
endinterface

// File: rtl/hwce_yin_streamer.sv
// hwce_yin_streamer: source of the shift-adder y_in partial-sum operand.
// Unpacks WPV stream words into one NPX x CONV_WIDTH vector, buffers vectors in
// a small FIFO and presents them to the adder. On a first input-channel pass
// (bias mode) no words are fetched and zero vectors are issued with
// sum_over_constant raised.
// Optional feature macro: HWCE_YIN_PERF_CNT_EN adds the stall_cycles counter.
module hwce_yin_streamer #(
   parameter int CONV_WIDTH   = 16,
   parameter int NPX          = 4,
   parameter int STREAM_WIDTH = 32,
   parameter int FIFO_DEPTH   = 4,
   parameter int CNT_WIDTH    = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [CNT_WIDTH-1:0] cfg_nb_vectors,
   input  logic                 cfg_first_pass,
   hwce_yin_streamer_if.master  bus,
   output logic                 busy,
   output logic                 done
`ifdef HWCE_YIN_PERF_CNT_EN
   ,
   output logic [31:0]          stall_cycles
`endif
);

   localparam int VEC_W = NPX * CONV_WIDTH;
   localparam int WPV   = VEC_W / STREAM_WIDTH;
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int IDX_W = (WPV > 1) ? $clog2(WPV) : 1;

   localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(WPV - 1);
   localparam logic [PTR_W:0]   DEPTH_CNT = (PTR_W + 1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {IDLE, FETCH, BIAS, DONE} state_t;

   state_t                state_reg;
   logic [CNT_WIDTH-1:0]  nb_reg;
   logic [CNT_WIDTH-1:0]  push_cnt_reg;
   logic [CNT_WIDTH-1:0]  pop_cnt_reg;
   logic [IDX_W-1:0]      w_reg;
   logic                  busy_reg;
   logic                  done_reg;
   logic                  bias_reg;

   logic [STREAM_WIDTH-1:0] unpack_reg [WPV];
   logic [VEC_W-1:0]        fifo_mem   [FIFO_DEPTH];
   logic [PTR_W-1:0]        wr_ptr_reg;
   logic [PTR_W-1:0]        rd_ptr_reg;
   logic [PTR_W:0]          count_reg;

   logic             fifo_empty;
   logic             fifo_full;
   logic             valid_y;
   logic             pop;
   logic             fifo_pop;
   logic             last_word;
   logic             ready_s;
   logic             accept;
   logic             push;
   logic             last_pop;
   logic [VEC_W-1:0] vec_asm;

   assign fifo_empty = (count_reg == '0);
   assign fifo_full  = (count_reg == DEPTH_CNT);

   // In bias mode the vector is always available; otherwise it comes from the FIFO.
   assign valid_y   = bias_reg || !fifo_empty;
   assign pop       = valid_y && bus.ready_in;
   assign fifo_pop  = pop && !fifo_empty;
   assign last_word = (w_reg == LAST_IDX);
   assign last_pop  = pop && (pop_cnt_reg == nb_reg - CNT_WIDTH'(1));

   // A non-final word only goes into the unpack buffer, so it may be taken even
   // with a full FIFO; the final word needs a free slot or a simultaneous pop.
   assign ready_s = (state_reg == FETCH) && (push_cnt_reg < nb_reg) &&
                    (!last_word || !fifo_full || fifo_pop);
   assign accept  = bus.stream_valid && ready_s;
   assign push    = accept && last_word;

   // Assemble the vector with the word currently on the bus in slot w, so the
   // final word lands in the FIFO the same cycle it is accepted.
   genvar gi;
   generate
      for (gi = 0; gi < WPV; gi++) begin : g_asm
         assign vec_asm[gi*STREAM_WIDTH +: STREAM_WIDTH] =
            (w_reg == IDX_W'(gi)) ? bus.stream_data : unpack_reg[gi];
      end
   endgenerate

   assign bus.stream_ready      = ready_s;
   assign bus.valid_y_in        = valid_y;
   assign bus.y_in              = fifo_empty ? '0 : fifo_mem[rd_ptr_reg];
   assign bus.sum_over_constant = bias_reg;
   assign busy                  = busy_reg;
   assign done                  = done_reg;

   // Job control FSM with counters, word index and registered status outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg    <= IDLE;
         nb_reg       <= '0;
         push_cnt_reg <= '0;
         pop_cnt_reg  <= '0;
         w_reg        <= '0;
         busy_reg     <= 1'b0;
         done_reg     <= 1'b0;
         bias_reg     <= 1'b0;
      end else begin
         done_reg <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (start) begin
                  nb_reg       <= cfg_nb_vectors;
                  push_cnt_reg <= '0;
                  pop_cnt_reg  <= '0;
                  w_reg        <= '0;
                  if (cfg_nb_vectors == '0) begin
                     state_reg <= DONE;
                     done_reg  <= 1'b1;
                  end else if (cfg_first_pass) begin
                     state_reg <= BIAS;
                     busy_reg  <= 1'b1;
                     bias_reg  <= 1'b1;
                  end else begin
                     state_reg <= FETCH;
                     busy_reg  <= 1'b1;
                  end
               end
            end
            FETCH, BIAS: begin
               if (accept) begin
                  w_reg <= last_word ? '0 : w_reg + IDX_W'(1);
               end
               if (push) begin
                  push_cnt_reg <= push_cnt_reg + CNT_WIDTH'(1);
               end
               if (pop) begin
                  pop_cnt_reg <= pop_cnt_reg + CNT_WIDTH'(1);
               end
               if (last_pop) begin
                  state_reg <= DONE;
                  done_reg  <= 1'b1;
                  busy_reg  <= 1'b0;
                  bias_reg  <= 1'b0;
               end
            end
            DONE: begin
               state_reg <= IDLE;
            end
            default: begin
               state_reg <= IDLE;
            end
         endcase
      end
   end

   // FIFO occupancy and pointers; push and pop may coincide even when full.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (push) begin
            wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
         end
         if (fifo_pop) begin
            rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
         end
         case ({push, fifo_pop})
            2'b10:   count_reg <= count_reg + (PTR_W + 1)'(1);
            2'b01:   count_reg <= count_reg - (PTR_W + 1)'(1);
            default: count_reg <= count_reg;
         endcase
      end
   end

   // Vector storage; contents are only visible through a non-zero occupancy.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_mem[wr_ptr_reg] <= vec_asm;
      end
   end

   // Unpack buffer; stale words are harmless because the index restarts at 0.
   always_ff @(posedge clk) begin
      if (accept) begin
         unpack_reg[w_reg] <= bus.stream_data;
      end
   end

`ifdef HWCE_YIN_PERF_CNT_EN
   logic [31:0] stall_cnt_reg;

   // Saturating count of cycles the adder holds off a presented vector.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt_reg <= '0;
      end else if (state_reg == IDLE && start) begin
         stall_cnt_reg <= '0;
      end else if (busy_reg && valid_y && !bus.ready_in && stall_cnt_reg != '1) begin
         stall_cnt_reg <= stall_cnt_reg + 32'd1;
      end
   end

   assign stall_cycles = stall_cnt_reg;
`endif

endmodule

// File: tb/tb_hwce_yin_streamer.sv
// Scoreboard bench for hwce_yin_streamer: jobs are modelled as lists of
// vectors; the words they pack into feed a stream driver and the vectors feed
// an expected queue that a negedge monitor drains on every y_in transfer.
module tb_hwce_yin_streamer;
   localparam int CW   = 16;
   localparam int NPX  = 4;
   localparam int SW   = 32;
   localparam int FD   = 4;
   localparam int CNTW = 16;
   localparam int VW   = CW * NPX;
   localparam int WPV  = VW / SW;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            start = 1'b0;
   logic [CNTW-1:0] cfg_nb = '0;
   logic            cfg_first = 1'b0;
   logic            busy;
   logic            done;
`ifdef HWCE_YIN_PERF_CNT_EN
   logic [31:0]     stall_cycles;
`endif

   hwce_yin_streamer_if #(.CONV_WIDTH(CW), .NPX(NPX), .STREAM_WIDTH(SW)) bus ();

   hwce_yin_streamer #(
      .CONV_WIDTH(CW), .NPX(NPX), .STREAM_WIDTH(SW), .FIFO_DEPTH(FD), .CNT_WIDTH(CNTW)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .start          (start),
      .cfg_nb_vectors (cfg_nb),
      .cfg_first_pass (cfg_first),
      .bus            (bus),
      .busy           (busy),
      .done           (done)
`ifdef HWCE_YIN_PERF_CNT_EN
      ,
      .stall_cycles   (stall_cycles)
`endif
   );

   always #5 clk = ~clk;

   int          checks = 0;
   int          failures = 0;
   int unsigned cyc = 0;
   int unsigned start_cyc = 0;
   int unsigned last_xfer_cyc = 0;

   logic [SW-1:0] words_q[$];
   logic [VW-1:0] exp_vec_q[$];
   bit            exp_soc_q[$];

   int  acc_words = 0;
   int  xfer_cnt = 0;
   int  vld_cnt = 0;
   int  sr_cnt = 0;
   int  done_cnt = 0;
   bit  sv_always = 0;
   int  rdy_mode = 1;   // 0 random, 1 low, 2 toggle, 4 high
   bit  take = 0;
   logic          prev_stall = 1'b0;
   logic          prev_done = 1'b0;
   logic [VW-1:0] prev_y = '0;

   task automatic check(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Stream source: presents the head word, retires it after an observed transfer.
   initial begin
      logic [SW-1:0] w;
      bus.stream_valid = 1'b0;
      bus.stream_data  = '0;
      forever begin
         @(posedge clk);
         #1;
         if (take && words_q.size() > 0) begin
            w = words_q.pop_front();
            acc_words++;
         end
         if (words_q.size() > 0 && (sv_always || $urandom_range(0, 3) != 0)) begin
            bus.stream_valid = 1'b1;
            bus.stream_data  = words_q[0];
         end else begin
            bus.stream_valid = 1'b0;
            bus.stream_data  = SW'($urandom);
         end
      end
   end

   // Adder-side ready generator.
   initial begin
      bus.ready_in = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         case (rdy_mode)
            0:       bus.ready_in = ($urandom_range(0, 3) != 0);
            1:       bus.ready_in = 1'b0;
            2:       bus.ready_in = ~bus.ready_in;
            default: bus.ready_in = 1'b1;
         endcase
      end
   end

   // Monitor: scoreboard drain, hold-stable check, done pulse width.
   always @(negedge clk) begin
      logic [VW-1:0] ev;
      bit            es;
      if (rst) begin
         prev_stall = 1'b0;
         prev_done  = 1'b0;
         take       = 1'b0;
      end else begin
         take = bus.stream_valid && bus.stream_ready;
         if (bus.stream_ready) sr_cnt++;
         if (bus.valid_y_in) vld_cnt++;
         if (prev_stall) begin
            check("hold_valid", VW'(bus.valid_y_in), VW'(1));
            check("hold_y_in", bus.y_in, prev_y);
         end
         if (bus.valid_y_in && bus.ready_in) begin
            if (exp_vec_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_vector: got 0x%0h expected none", bus.y_in);
            end else begin
               ev = exp_vec_q.pop_front();
               es = exp_soc_q.pop_front();
               check("y_in", bus.y_in, ev);
               check("sum_over_constant", VW'(bus.sum_over_constant), VW'(es));
            end
            xfer_cnt++;
            last_xfer_cyc = cyc;
         end
         if (done) begin
            done_cnt++;
            check("done_pulse_width", VW'(prev_done), VW'(0));
         end
         prev_done  = done;
         prev_stall = bus.valid_y_in && !bus.ready_in;
         prev_y     = bus.y_in;
      end
   end

   // Build a job: bias jobs expect nb zero vectors; fetch jobs expect the
   // vectors whose packed words are queued on the stream, plus junk words that
   // must never be taken.
   task automatic prep_job(input int nb, input bit first, input bit seq, input int junk);
      logic [VW-1:0] vec;
      logic [CW-1:0] pix;
      words_q.delete();
      exp_vec_q.delete();
      exp_soc_q.delete();
      acc_words = 0;
      xfer_cnt  = 0;
      vld_cnt   = 0;
      sr_cnt    = 0;
      done_cnt  = 0;
      for (int v = 0; v < nb; v++) begin
         if (first) begin
            exp_vec_q.push_back('0);
            exp_soc_q.push_back(1'b1);
         end else begin
            for (int p = 0; p < NPX; p++) begin
               pix = seq ? CW'(v * NPX + p + 1) : CW'($urandom);
               vec[p*CW +: CW] = pix;
            end
            exp_vec_q.push_back(vec);
            exp_soc_q.push_back(1'b0);
            for (int k = 0; k < WPV; k++) words_q.push_back(vec[k*SW +: SW]);
         end
      end
      for (int j = 0; j < junk; j++) words_q.push_back(SW'($urandom));
   endtask

   task automatic start_job(input int nb, input bit first);
      @(posedge clk);
      #2;
      start     = 1'b1;
      cfg_nb    = CNTW'(nb);
      cfg_first = first;
      @(posedge clk);
      #2;
      start     = 1'b0;
      start_cyc = cyc;
   endtask

   task automatic finish_job(input int nb, input bit first);
      int n = 0;
      bit seen = 0;
      while (!seen && n < 3000) begin
         @(negedge clk);
         #1;
         seen = done;
         n++;
      end
      if (!seen) begin
         checks++;
         failures++;
         $display("FAIL done_timeout: got no done expected done within 3000 cycles");
      end else begin
         check("busy_at_done", VW'(busy), VW'(0));
         check("transfers", VW'(xfer_cnt), VW'(nb));
         check("words_accepted", VW'(acc_words), VW'(first ? 0 : nb * WPV));
         check("pending_vectors", VW'(exp_vec_q.size()), VW'(0));
         if (nb > 0) check("done_latency", VW'(cyc), VW'(last_xfer_cyc + 1));
         else begin
            check("zero_job_done_latency", VW'(cyc), VW'(start_cyc));
            check("zero_job_valid_cycles", VW'(vld_cnt), VW'(0));
         end
         if (first) check("bias_stream_ready_cycles", VW'(sr_cnt), VW'(0));
      end
      @(negedge clk);
      #1;
      check("done_after_pulse", VW'(done), VW'(0));
      check("busy_after_done", VW'(busy), VW'(0));
      words_q.delete();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      repeat (3) @(posedge clk);
      #2;
      check("reset_valid_y_in", VW'(bus.valid_y_in), VW'(0));
      check("reset_stream_ready", VW'(bus.stream_ready), VW'(0));
      check("reset_y_in", bus.y_in, '0);
      check("reset_busy", VW'(busy), VW'(0));
      rst = 1'b0;

      // Fetch basic: sequential pixels, adder always ready.
      prep_job(3, 0, 1, 2);
      sv_always = 1;
      rdy_mode  = 4;
      start_job(3, 0);
      finish_job(3, 0);

      // Backpressure: the FIFO fills and one more word sits in the unpack
      // buffer before the final word of the next vector is refused.
      prep_job(8, 0, 0, 2);
      rdy_mode = 1;
      start_job(8, 0);
      repeat (30) @(negedge clk);
      #1;
      check("bp_words_accepted", VW'(acc_words), VW'(FD * WPV + WPV - 1));
      check("bp_stream_ready", VW'(bus.stream_ready), VW'(0));
      check("bp_no_transfers", VW'(xfer_cnt), VW'(0));
      rdy_mode = 0;
      finish_job(8, 0);

      // Bias mode with toggling ready.
      sv_always = 0;
      prep_job(5, 1, 0, 3);
      rdy_mode = 2;
      start_job(5, 1);
      finish_job(5, 1);

      // Zero-length job.
      prep_job(0, 0, 0, 2);
      rdy_mode = 0;
      start_job(0, 0);
      finish_job(0, 0);

      // Start while busy is ignored.
      prep_job(6, 0, 0, 0);
      start_job(6, 0);
      repeat (3) @(posedge clk);
      #2;
      start     = 1'b1;
      cfg_nb    = CNTW'(1);
      cfg_first = 1'b1;
      @(posedge clk);
      #2;
      start = 1'b0;
      finish_job(6, 0);
      repeat (4) @(negedge clk);
      #1;
      check("restart_ignored_done_count", VW'(done_cnt), VW'(1));

      // Reset in the middle of a vector.
      prep_job(2, 0, 0, 0);
      sv_always = 1;
      rdy_mode  = 1;
      start_job(2, 0);
      n = 0;
      while (acc_words < 1 && n < 50) begin
         @(posedge clk);
         #2;
         n++;
      end
      check("rst_setup_words", VW'(acc_words), VW'(1));
      rst = 1'b1;
      #1;
      check("rst_stream_ready", VW'(bus.stream_ready), VW'(0));
      check("rst_valid_y_in", VW'(bus.valid_y_in), VW'(0));
      check("rst_y_in", bus.y_in, '0);
      check("rst_sum_over_constant", VW'(bus.sum_over_constant), VW'(0));
      check("rst_busy", VW'(busy), VW'(0));
      check("rst_done", VW'(done), VW'(0));
      repeat (2) @(negedge clk);
      #1;
      rst = 1'b0;
      sv_always = 0;
      prep_job(2, 0, 0, 0);
      rdy_mode = 0;
      start_job(2, 0);
      finish_job(2, 0);

      // Randomized jobs.
      for (int i = 0; i < 6; i++) begin
         int nb;
         bit first;
         nb    = $urandom_range(1, 10);
         first = ($urandom_range(0, 3) == 0);
         prep_job(nb, first, 0, 3);
         rdy_mode = 0;
         start_job(nb, first);
         finish_job(nb, first);
      end

`ifdef HWCE_YIN_PERF_CNT_EN
      // Seven stalled busy cycles before the adder accepts.
      prep_job(2, 1, 0, 0);
      rdy_mode = 1;
      start_job(2, 1);
      repeat (7) @(posedge clk);
      rdy_mode = 4;
      finish_job(2, 1);
      check("stall_cycles", VW'(stall_cycles), VW'(7));
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
